// File: rtl/sramx_mem_responder.sv
// SRAM-x responder: word-addressed RAM plus a 16-byte MMIO window.
// Every accepted request is answered with read-first rdata one cycle later.
module sramx_mem_responder #(
   parameter int          DEPTH_LOG2 = 12,
   parameter logic [31:0] MMIO_BASE  = 32'h1FAF_0000,
   parameter logic [31:0] BAD_DATA   = 32'hDEAD_BEEF
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        en,
   input  logic [3:0]  wen,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic [15:0] led,
   output logic        err
);

   localparam int WORDS = 1 << DEPTH_LOG2;

   logic [31:0]           mem [WORDS];
   logic [31:0]           scratch;
   logic [31:0]           counter;
   logic [DEPTH_LOG2-1:0] ram_idx;
   logic [1:0]            reg_sel;
   logic                  ram_hit;
   logic                  mmio_hit;
   logic                  unmapped;
   logic [31:0]           rd_val;
   logic [31:0]           led_merged;
   logic                  err_clr;
   logic                  unused_bits;

   function automatic logic [31:0] merge_lanes(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  lanes);
      logic [31:0] res;
      res = old_val;
      for (int i = 0; i < 4; i++)
         if (lanes[i]) res[8*i +: 8] = new_val[8*i +: 8];
      return res;
   endfunction

   assign unused_bits = ^addr[1:0];
   assign ram_idx     = addr[DEPTH_LOG2+1:2];
   assign reg_sel     = addr[3:2];
   assign ram_hit     = (addr[31:DEPTH_LOG2+2] == '0);
   assign mmio_hit    = (addr[31:4] == MMIO_BASE[31:4]);
   assign unmapped    = en && !ram_hit && !mmio_hit;
   assign led_merged  = merge_lanes({16'h0, led}, wdata, wen);
   assign err_clr     = en && mmio_hit && (reg_sel == 2'd3) && wen[0] && wdata[0];

   always_comb begin
      rd_val = BAD_DATA;
      if (ram_hit) begin
         rd_val = mem[ram_idx];
      end else if (mmio_hit) begin
         case (reg_sel)
            2'd0:    rd_val = scratch;
            2'd1:    rd_val = counter;
            2'd2:    rd_val = {16'h0, led};
            default: rd_val = {31'h0, err};
         endcase
      end
   end

   // RAM array carries no reset so its contents survive resetn.
   always_ff @(posedge clk) begin
      if (en && ram_hit)
         mem[ram_idx] <= merge_lanes(mem[ram_idx], wdata, wen);
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         rdata   <= '0;
         led     <= '0;
         err     <= 1'b0;
         scratch <= '0;
         counter <= '0;
      end else begin
         // A counter write replaces this cycle's increment; untouched lanes keep the old value.
         if (en && mmio_hit && (reg_sel == 2'd1) && (wen != 4'h0))
            counter <= merge_lanes(counter, wdata, wen);
         else
            counter <= counter + 32'd1;

         if (en) begin
            rdata <= rd_val;
            if (mmio_hit && (reg_sel == 2'd0))
               scratch <= merge_lanes(scratch, wdata, wen);
            if (mmio_hit && (reg_sel == 2'd2))
               led <= led_merged[15:0];
         end

         if (unmapped)
            err <= 1'b1;
         else if (err_clr)
            err <= 1'b0;
      end
   end

endmodule

// File: tb/tb_sramx_mem_responder.sv
// Directed bench for sramx_mem_responder with a queue of expected rdata values.
module tb_sramx_mem_responder;

   localparam logic [31:0] MMIO_BASE = 32'h1FAF_0000;
   localparam logic [31:0] BAD_DATA  = 32'hDEAD_BEEF;

   logic        clk = 1'b0;
   logic        resetn;
   logic        en;
   logic [3:0]  wen;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic [15:0] led;
   logic        err;

   logic [31:0] exp_q[$];
   int          passed = 0;
   int          total  = 0;
   int          fails  = 0;
   logic [31:0] cnt_m  = '0;

   sramx_mem_responder #(
      .DEPTH_LOG2(12),
      .MMIO_BASE (MMIO_BASE),
      .BAD_DATA  (BAD_DATA)
   ) dut (
      .clk   (clk),
      .resetn(resetn),
      .en    (en),
      .wen   (wen),
      .addr  (addr),
      .wdata (wdata),
      .rdata (rdata),
      .led   (led),
      .err   (err)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d,
                                         input logic [3:0] w);
      logic [31:0] r;
      r = o;
      for (int i = 0; i < 4; i++)
         if (w[i]) r[8*i +: 8] = d[8*i +: 8];
      return r;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv) passed++;
      else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   // One clock edge; when push is set the expected rdata is queued and checked after the edge.
   task automatic step(input string tag, input logic e, input logic [3:0] w,
                       input logic [31:0] a, input logic [31:0] d,
                       input logic push, input logic [31:0] expv);
      en = e; wen = w; addr = a; wdata = d;
      if (push) exp_q.push_back(expv);
      @(posedge clk);
      #1;
      if (e && (a[31:4] == MMIO_BASE[31:4]) && (a[3:2] == 2'd1) && (w != 4'h0))
         cnt_m = merge(cnt_m, d, w);
      else
         cnt_m = cnt_m + 32'd1;
      if (push) begin
         if (exp_q.size() == 0) check({tag, "_queue"}, 32'd0, 32'd1);
         else check(tag, rdata, exp_q.pop_front());
      end
      en = 1'b0; wen = 4'h0;
   endtask

   task automatic release_reset();
      @(negedge clk);
      resetn = 1'b1;
      cnt_m  = '0;
   endtask

   initial begin
      resetn = 1'b0; en = 1'b0; wen = 4'h0; addr = '0; wdata = '0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_rdata", rdata, 32'h0);
      check("reset_led", {16'h0, led}, 32'h0);
      check("reset_err", {31'h0, err}, 32'h0);
      release_reset();

      step("cnt_first", 1'b1, 4'h0, MMIO_BASE + 32'h4, '0, 1'b1, 32'h0);

      step("ram_pre",  1'b1, 4'hF, 32'h0000_0010, 32'h1122_3344, 1'b0, '0);
      step("ram_wr",   1'b1, 4'hF, 32'h0000_0010, 32'h1234_5678, 1'b1, 32'h1122_3344);
      step("ram_rd",   1'b1, 4'h0, 32'h0000_0010, 32'h0,         1'b1, 32'h1234_5678);

      step("part_pre", 1'b1, 4'hF, 32'h0000_0020, 32'h1122_3344, 1'b0, '0);
      step("part_wr",  1'b1, 4'b0101, 32'h0000_0020, 32'hAABB_CCDD, 1'b1, 32'h1122_3344);
      step("part_rd",  1'b1, 4'h0, 32'h0000_0020, 32'h0,         1'b1, 32'h11BB_33DD);

      step("cnt_rd_a", 1'b1, 4'h0, MMIO_BASE + 32'h4, '0, 1'b1, cnt_m);
      step("cnt_rd_b", 1'b1, 4'h0, MMIO_BASE + 32'h4, '0, 1'b1, cnt_m);
      step("cnt_wr",   1'b1, 4'hF, MMIO_BASE + 32'h4, 32'hFFFF_FFFF, 1'b1, cnt_m);
      step("cnt_max",  1'b1, 4'h0, MMIO_BASE + 32'h4, '0, 1'b1, 32'hFFFF_FFFF);
      step("cnt_wrap", 1'b1, 4'h0, MMIO_BASE + 32'h4, '0, 1'b1, 32'h0000_0000);

      step("scr_wr",   1'b1, 4'b0011, MMIO_BASE, 32'hCAFE_F00D, 1'b1, 32'h0);
      step("scr_rd",   1'b1, 4'h0,    MMIO_BASE, 32'h0,         1'b1, 32'h0000_F00D);

      step("led_wr",   1'b1, 4'hF, MMIO_BASE + 32'h8, 32'h0001_ABCD, 1'b1, 32'h0);
      check("led_out", {16'h0, led}, 32'h0000_ABCD);
      step("led_rd",   1'b1, 4'h0, MMIO_BASE + 32'h8, 32'h0, 1'b1, 32'h0000_ABCD);

      check("err_clean", {31'h0, err}, 32'h0);
      step("unm_rd",   1'b1, 4'h0, 32'h8000_0000, 32'h0, 1'b1, BAD_DATA);
      check("err_set", {31'h0, err}, 32'h1);
      step("unm_wr",   1'b1, 4'hF, 32'h0000_4000, 32'h5555_5555, 1'b1, BAD_DATA);
      step("stat_rd",  1'b1, 4'h0, MMIO_BASE + 32'hC, 32'h0, 1'b1, 32'h1);
      step("stat_w1c", 1'b1, 4'h1, MMIO_BASE + 32'hC, 32'h1, 1'b1, 32'h1);
      check("err_clr", {31'h0, err}, 32'h0);
      step("stat_rd0", 1'b1, 4'h0, MMIO_BASE + 32'hC, 32'h0, 1'b1, 32'h0);

      step("hold_pre", 1'b1, 4'h0, 32'h0000_0010, 32'h0, 1'b1, 32'h1234_5678);
      step("hold_en0", 1'b0, 4'hF, 32'h0000_0010, 32'hFFFF_FFFF, 1'b1, 32'h1234_5678);
      step("hold_chk", 1'b1, 4'h0, 32'h0000_0010, 32'h0, 1'b1, 32'h1234_5678);

      step("unm_again", 1'b1, 4'h0, 32'h8000_0000, 32'h0, 1'b1, BAD_DATA);
      step("rst_wr",   1'b1, 4'hF, 32'h0000_0030, 32'h5A5A_0F0F, 1'b0, '0);
      resetn = 1'b0;
      #1;
      check("async_rdata", rdata, 32'h0);
      check("async_led", {16'h0, led}, 32'h0);
      check("async_err", {31'h0, err}, 32'h0);
      repeat (2) @(posedge clk);
      release_reset();
      step("cnt_rel",  1'b1, 4'h0, MMIO_BASE + 32'h4, '0, 1'b1, 32'h0);
      step("ram_keep", 1'b1, 4'h0, 32'h0000_0030, 32'h0, 1'b1, 32'h5A5A_0F0F);
      step("scr_rst",  1'b1, 4'h0, MMIO_BASE, 32'h0, 1'b1, 32'h0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
